uart_tx_arbiter: RTL

Shares the single serial line to the FT2232 (`o_UART_RX`, idle high) between two byte sources: the 6809 UART data-register write path (CPU) and the internal monitor/debug source (MON). The block runs a fair round-robin arbiter and an 8N1 transmit sequencer driven by a per-bit clock-enable counter. It sits between the 6809 bus interface logic and the FT2232 pins. It is the transmit counterpart of the existing UART receive/register block.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter between CPU and monitor byte sources feeding one 8N1
// serial transmitter; the line idles high and every output is registered.
module uart_tx_arbiter #(
  parameter int CLOCK_DIVISOR = 4618
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_ENABLE,
  input  logic       i_CPU_REQ,
  input  logic [7:0] i_CPU_DATA,
  output logic       o_CPU_ACK,
  input  logic       i_MON_REQ,
  input  logic [7:0] i_MON_DATA,
  output logic       o_MON_ACK,
  output logic       o_UART_RX,
  output logic       o_BUSY,
  output logic       o_LAST_GRANT
);

  localparam logic [12:0] BAUD_LAST = 13'(CLOCK_DIVISOR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [12:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift_reg, shift_reg_nxt;
  logic        uart_rx_nxt, cpu_ack_nxt, mon_ack_nxt, busy_nxt, last_grant_nxt;
  logic        grant_cpu, grant_mon;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      o_UART_RX    <= 1'b1;
      o_CPU_ACK    <= 1'b0;
      o_MON_ACK    <= 1'b0;
      o_BUSY       <= 1'b0;
      o_LAST_GRANT <= 1'b1;
    end else begin
      state        <= state_nxt;
      baud_cnt     <= baud_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift_reg    <= shift_reg_nxt;
      o_UART_RX    <= uart_rx_nxt;
      o_CPU_ACK    <= cpu_ack_nxt;
      o_MON_ACK    <= mon_ack_nxt;
      o_BUSY       <= busy_nxt;
      o_LAST_GRANT <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    baud_cnt_nxt   = baud_cnt;
    bit_cnt_nxt    = bit_cnt;
    shift_reg_nxt  = shift_reg;
    uart_rx_nxt    = o_UART_RX;
    cpu_ack_nxt    = 1'b0;
    mon_ack_nxt    = 1'b0;
    busy_nxt       = o_BUSY;
    last_grant_nxt = o_LAST_GRANT;
    grant_cpu      = 1'b0;
    grant_mon      = 1'b0;

    case (state)
      IDLE: begin
        uart_rx_nxt = 1'b1;
        busy_nxt    = 1'b0;
        // On a tie the requester not served last wins.
        if (i_ENABLE) begin
          grant_cpu = i_CPU_REQ && (!i_MON_REQ || o_LAST_GRANT);
          grant_mon = i_MON_REQ && (!i_CPU_REQ || !o_LAST_GRANT);
        end
        if (grant_cpu || grant_mon) begin
          shift_reg_nxt  = grant_cpu ? i_CPU_DATA : i_MON_DATA;
          cpu_ack_nxt    = grant_cpu;
          mon_ack_nxt    = grant_mon;
          last_grant_nxt = grant_mon;
          bit_cnt_nxt    = '0;
          baud_cnt_nxt   = '0;
          uart_rx_nxt    = 1'b0;
          busy_nxt       = 1'b1;
          state_nxt      = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          uart_rx_nxt  = shift_reg[0];
          state_nxt    = DATA;
        end else begin
          baud_cnt_nxt = baud_cnt + 13'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_nxt  = '0;
          shift_reg_nxt = {1'b0, shift_reg[7:1]};
          bit_cnt_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            uart_rx_nxt = 1'b1;
            state_nxt   = STOP;
          end else begin
            uart_rx_nxt = shift_reg[1];
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 13'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          uart_rx_nxt  = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end else begin
          baud_cnt_nxt = baud_cnt + 13'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
